first_nios2_system_sysid_arbiter: RTL

FIRST_NIOS2_SYSTEM_SYSID_ARBITER -- requirements
Module: first_nios2_system_sysid_arbiter

---
 rtl/first_nios2_system_sysid_arbiter_if.sv | 40 ++++
 rtl/first_nios2_system_sysid_arbiter.sv | 102 ++++++++++
 2 files changed

// File: rtl/first_nios2_system_sysid_arbiter_if.sv
// Two-master read bus plus the shared sysid slave port.
// slave = arbiter view, master = environment view.
interface first_nios2_system_sysid_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  m0_read;
  logic                  m0_address;
  logic                  m0_waitrequest;
  logic [DATA_WIDTH-1:0] m0_readdata;
  logic                  m0_readdatavalid;
  logic                  m1_read;
  logic                  m1_address;
  logic                  m1_waitrequest;
  logic [DATA_WIDTH-1:0] m1_readdata;
  logic                  m1_readdatavalid;
  logic                  s_address;
  logic [DATA_WIDTH-1:0] s_readdata;

  modport slave (
    input  m0_read, m0_address,
    input  m1_read, m1_address,
    input  s_readdata,
    output m0_waitrequest, m0_readdata,
    output m0_readdatavalid,
    output m1_waitrequest, m1_readdata,
    output m1_readdatavalid,
    output s_address
  );

  modport master (
    output m0_read, m0_address,
    output m1_read, m1_address,
    output s_readdata,
    input  m0_waitrequest, m0_readdata,
    input  m0_readdatavalid,
    input  m1_waitrequest, m1_readdata,
    input  m1_readdatavalid,
    input  s_address
  );
endinterface

// File: rtl/first_nios2_system_sysid_arbiter.sv
// Two-master arbiter in front of a combinational sysid slave.
// IDLE/ACCEPT/RESP, one read in flight, all outputs registered.
module first_nios2_system_sysid_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int RR_ENABLE  = 1
) (
  input logic clock,
  input logic reset_n,
  first_nios2_system_sysid_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  logic ready;
  logic grant_sel;
  logic last_grant;
  logic s_address;
  logic wait0, wait1;
  logic valid0, valid1;
  logic [DATA_WIDTH-1:0] data0, data1;

  logic any_req, both_req;
  logic win, win_addr, cur_read;

  always_comb begin
    any_req  = bus.m0_read | bus.m1_read;
    both_req = bus.m0_read & bus.m1_read;
    win      = bus.m1_read;
    if (both_req)
      win = (RR_ENABLE != 0) ? ~last_grant : 1'b0;
    win_addr = win ? bus.m1_address
                   : bus.m0_address;
    cur_read = grant_sel ? bus.m1_read
                         : bus.m0_read;
  end

  // ready delays the first grant until one edge after reset release
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ready      <= 1'b0;
      grant_sel  <= 1'b0;
      last_grant <= 1'b1;
      s_address  <= 1'b0;
      wait0      <= 1'b1;
      wait1      <= 1'b1;
      valid0     <= 1'b0;
      valid1     <= 1'b0;
      data0      <= '0;
      data1      <= '0;
    end else begin
      ready  <= 1'b1;
      wait0  <= 1'b1;
      wait1  <= 1'b1;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      unique case (state)
        IDLE, RESP: begin
          if (ready && any_req) begin
            grant_sel <= win;
            s_address <= win_addr;
            wait0     <= win;
            wait1     <= ~win;
            state     <= ACCEPT;
          end else begin
            state <= IDLE;
          end
        end
        ACCEPT: begin
          if (cur_read) begin
            last_grant <= grant_sel;
            if (grant_sel) begin
              data1  <= bus.s_readdata;
              valid1 <= 1'b1;
            end else begin
              data0  <= bus.s_readdata;
              valid0 <= 1'b1;
            end
            state <= RESP;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m0_waitrequest   = wait0;
  assign bus.m1_waitrequest   = wait1;
  assign bus.m0_readdatavalid = valid0;
  assign bus.m1_readdatavalid = valid1;
  assign bus.m0_readdata      = data0;
  assign bus.m1_readdata      = data1;
  assign bus.s_address        = s_address;

endmodule
